// File: rtl/adc_jesd204_capture_pkg.sv
// Shared types and helpers for the JESD204 ADC capture FIFO.
// Holds the capture FSM encoding and the channel slice width helper.
package adc_jesd204_capture_pkg;

  localparam int OVF_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } capture_state_e;

  function automatic int chan_width(int dw, int nch);
    return dw / nch;
  endfunction

endpackage

// File: rtl/adc_jesd204_capture_fifo_mem.sv
// Single-clock dual-port RAM, synchronous write, asynchronous read.
// The asynchronous read port gives the FIFO its fall-through head.
module adc_jesd204_capture_fifo_mem #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/adc_jesd204_capture_fifo.sv
// JESD204 ADC capture FIFO: arms on a DMA request, aligns on a
// full-channel beat, buffers samples and flags/counts overflows.
module adc_jesd204_capture_fifo
  import adc_jesd204_capture_pkg::*;
#(
  parameter int NUM_CHANNELS       = 4,
  parameter int DATA_WIDTH         = 64,
  parameter int FIFO_DEPTH_LOG2    = 6,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                       adc_clk,
  input  logic                       adc_rst,
  input  logic [NUM_CHANNELS-1:0]    adc_enable,
  input  logic [NUM_CHANNELS-1:0]    adc_valid,
  input  logic [DATA_WIDTH-1:0]      adc_data,
  output logic                       adc_dovf,
  input  logic                       dma_xfer_req,
  output logic                       dma_valid,
  output logic [DATA_WIDTH-1:0]      dma_data,
  input  logic                       dma_ready,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic                       fifo_almost_full,
  input  logic                       ovf_clear,
  output logic [OVF_COUNT_WIDTH-1:0] ovf_count
);

  localparam int CW    = chan_width(DATA_WIDTH, NUM_CHANNELS);
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;

  capture_state_e state_q, state_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          dovf_q, dovf_d;
  logic [OVF_COUNT_WIDTH-1:0] ovf_q, ovf_d;

  logic [NUM_CHANNELS-1:0] beat_mask;
  logic beat, aligned;
  logic full, empty, pop;
  logic wr_en, drop;
  logic [DATA_WIDTH-1:0] wdata, rdata;

  assign beat_mask = adc_valid & adc_enable;
  assign beat      = |beat_mask;
  assign aligned   = (beat_mask == adc_enable) && (|adc_enable);

  // Disabled channels are written as zero.
  always_comb begin
    wdata = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (adc_enable[k]) begin
        wdata[k*CW +: CW] = adc_data[k*CW +: CW];
      end
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign pop   = dma_valid & dma_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = 1'b0;
    drop     = 1'b0;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        if (dma_xfer_req) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (!dma_xfer_req) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else if (aligned) begin
          wr_en   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Disarm flushes on the same edge; any beat is discarded.
        if (!dma_xfer_req) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else if (beat) begin
          if (!full || pop) begin
            wr_en = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end
    endcase
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  assign level_d = wr_ptr_d - rd_ptr_d;
  assign dovf_d  = drop;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clear) begin
      ovf_d = {{(OVF_COUNT_WIDTH-1){1'b0}}, drop};
    end else if (drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dovf_q   <= 1'b0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dovf_q   <= dovf_d;
      ovf_q    <= ovf_d;
    end
  end

  adc_jesd204_capture_fifo_mem #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_mem (
    .clk_i   (adc_clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[PW-2:0]),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q[PW-2:0]),
    .rdata_o (rdata)
  );

  assign dma_valid        = !empty;
  assign dma_data         = dma_valid ? rdata : '0;
  assign fifo_level       = level_q;
  assign fifo_almost_full = (PW'(DEPTH) - level_q) <= PW'(ALMOST_FULL_MARGIN);
  assign adc_dovf         = dovf_q;
  assign ovf_count        = ovf_q;

endmodule
